// File: rtl/bp_unit.sv
// bp_unit: address breakpoints, N-instruction stepping and code-bus arbitration
//   between the target core and its code ROM, driven by visor register writes.
// Latency: match is combinational on tg_code_addr; state/halted/hit_idx register
//   one cycle after the qualifying edge. tg_code_in/tg_code_ready are combinational.
// Backpressure: while HALTED the target is stalled by holding tg_code_ready low,
//   unless the visor has taken the bus (divert), in which case force_ready drives it.
//
// Ports:
//   sysclk, sysreset (async, active-high)
//   rom_code_in/rom_code_ready       : ROM side of the code bus
//   tg_code_addr/tg_code_in/ready    : target side of the code bus
//   tg_debug_loading_exr/enable_exec : target pipeline status
//   divert/force_opcode/force_ready  : visor override of the code bus
//   bp_wr*                           : breakpoint table write port
//   step_load/step_count, resume     : run control
//   halted, hit_idx, exr_shadow, step_left, hit_count : status
// Optional feature macro: BP_HIT_COUNT_EN enables saturating per-breakpoint
//   hit counters; when undefined hit_count is tied to zero.
module bp_unit #(
  parameter int NUM_BP = 4,
  parameter int STEP_W = 8
) (
  input  logic                sysclk,
  input  logic                sysreset,
  input  logic [15:0]         rom_code_in,
  input  logic                rom_code_ready,
  input  logic [15:0]         tg_code_addr,
  output logic [15:0]         tg_code_in,
  output logic                tg_code_ready,
  input  logic                tg_debug_loading_exr,
  input  logic                tg_debug_enable_exec,
  input  logic                divert,
  input  logic [15:0]         force_opcode,
  input  logic                force_ready,
  input  logic                bp_wr,
  input  logic [3:0]          bp_wr_idx,
  input  logic [15:0]         bp_wr_addr,
  input  logic [15:0]         bp_wr_mask,
  input  logic                bp_wr_en,
  input  logic                step_load,
  input  logic [STEP_W-1:0]   step_count,
  input  logic                resume,
  output logic                halted,
  output logic [3:0]          hit_idx,
  output logic [15:0]         exr_shadow,
  output logic [STEP_W-1:0]   step_left,
  output logic [8*NUM_BP-1:0] hit_count
);

  typedef enum logic [1:0] {RUN, ARMED, HALTED} state_t;

  localparam logic [3:0] STEP_IDX = 4'(NUM_BP);

  state_t              state;
  logic [15:0]         bp_addr [NUM_BP];
  logic [15:0]         bp_mask [NUM_BP];
  logic [NUM_BP-1:0]   bp_en;
  logic [15:0]         skip_addr;
  logic                skip_valid;

  logic [NUM_BP-1:0]   match;
  logic                match_any;
  logic [3:0]          match_idx;
  logic                bp_wr_ok;
  logic                step_fire;

  // Lowest index wins: scan downwards so the last assignment is the lowest hit.
  always_comb begin
    match     = '0;
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_en[i] && (((tg_code_addr ^ bp_addr[i]) & ~bp_mask[i]) == 16'h0000);
    end
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (match[i]) begin
        match_any = 1'b1;
        match_idx = 4'(i);
      end
    end
    // Just resumed from this address: let the target leave without re-hitting.
    if (skip_valid && (tg_code_addr == skip_addr)) match_any = 1'b0;
  end

  assign bp_wr_ok = bp_wr && (bp_wr_idx < STEP_IDX);

  // Last step decrement; a simultaneous step_load takes precedence over it.
  assign step_fire = (state == RUN) && tg_debug_enable_exec && !step_load &&
                     (step_left == STEP_W'(1));

  assign tg_code_in    = divert ? force_opcode : rom_code_in;
  assign tg_code_ready = divert ? force_ready  : (rom_code_ready && (state != HALTED));

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state      <= RUN;
      halted     <= 1'b0;
      hit_idx    <= '0;
      exr_shadow <= '0;
      step_left  <= '0;
      skip_addr  <= '0;
      skip_valid <= 1'b0;
      bp_en      <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr[i] <= '0;
        bp_mask[i] <= '0;
      end
    end else begin
      if (tg_debug_loading_exr && !divert) exr_shadow <= rom_code_in;

      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr && (bp_wr_idx == 4'(i))) begin
          bp_addr[i] <= bp_wr_addr;
          bp_mask[i] <= bp_wr_mask;
          bp_en[i]   <= bp_wr_en;
        end
      end

      if (step_load)
        step_left <= step_count;
      else if ((state == RUN) && tg_debug_enable_exec && (step_left != '0))
        step_left <= step_left - STEP_W'(1);

      if ((state == HALTED) && resume) begin
        skip_addr  <= tg_code_addr;
        skip_valid <= 1'b1;
      end else if (skip_valid && (tg_code_addr != skip_addr)) begin
        skip_valid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (step_fire) begin
            state   <= HALTED;
            halted  <= 1'b1;
            hit_idx <= STEP_IDX;
          end else if (match_any) begin
            hit_idx <= match_idx;
            if (tg_debug_enable_exec) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              // Wait for an ordinary cycle so the visor can refill EXR first.
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (bp_wr_ok) begin
            state <= RUN;
          end else if (tg_debug_enable_exec) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef BP_HIT_COUNT_EN
  logic [7:0] hit_cnt [NUM_BP];
  logic       halt_bp;
  logic [3:0] halt_bp_idx;

  // Entry to HALTED caused by a breakpoint (not by the step counter).
  always_comb begin
    halt_bp     = 1'b0;
    halt_bp_idx = '0;
    if ((state == RUN) && !step_fire && match_any && tg_debug_enable_exec) begin
      halt_bp     = 1'b1;
      halt_bp_idx = match_idx;
    end else if ((state == ARMED) && !bp_wr_ok && tg_debug_enable_exec) begin
      halt_bp     = 1'b1;
      halt_bp_idx = hit_idx;
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int i = 0; i < NUM_BP; i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr && (bp_wr_idx == 4'(i)))
          hit_cnt[i] <= '0;
        else if (halt_bp && (halt_bp_idx == 4'(i)) && (hit_cnt[i] != 8'hFF))
          hit_cnt[i] <= hit_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) hit_count[8*i +: 8] = hit_cnt[i];
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_bp_unit.sv
// tb_bp_unit: directed self-checking bench for bp_unit (NUM_BP=4, STEP_W=8).
// Code-bus mux checked from a vector table; breakpoint, skip, step and reset
// behaviour checked with hand-written multi-cycle sequences.
module tb_bp_unit;

  localparam int NUM_BP = 4;
  localparam int STEP_W = 8;

  logic                sysclk = 1'b0;
  logic                sysreset;
  logic [15:0]         rom_code_in;
  logic                rom_code_ready;
  logic [15:0]         tg_code_addr;
  logic [15:0]         tg_code_in;
  logic                tg_code_ready;
  logic                tg_debug_loading_exr;
  logic                tg_debug_enable_exec;
  logic                divert;
  logic [15:0]         force_opcode;
  logic                force_ready;
  logic                bp_wr;
  logic [3:0]          bp_wr_idx;
  logic [15:0]         bp_wr_addr;
  logic [15:0]         bp_wr_mask;
  logic                bp_wr_en;
  logic                step_load;
  logic [STEP_W-1:0]   step_count;
  logic                resume;
  logic                halted;
  logic [3:0]          hit_idx;
  logic [15:0]         exr_shadow;
  logic [STEP_W-1:0]   step_left;
  logic [8*NUM_BP-1:0] hit_count;

  bp_unit #(.NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
    .sysclk(sysclk), .sysreset(sysreset),
    .rom_code_in(rom_code_in), .rom_code_ready(rom_code_ready),
    .tg_code_addr(tg_code_addr), .tg_code_in(tg_code_in), .tg_code_ready(tg_code_ready),
    .tg_debug_loading_exr(tg_debug_loading_exr), .tg_debug_enable_exec(tg_debug_enable_exec),
    .divert(divert), .force_opcode(force_opcode), .force_ready(force_ready),
    .bp_wr(bp_wr), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr),
    .bp_wr_mask(bp_wr_mask), .bp_wr_en(bp_wr_en),
    .step_load(step_load), .step_count(step_count), .resume(resume),
    .halted(halted), .hit_idx(hit_idx), .exr_shadow(exr_shadow),
    .step_left(step_left), .hit_count(hit_count)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        div;
    logic [15:0] fop;
    logic        frdy;
    logic [15:0] rom;
    logic        rrdy;
    logic [15:0] exp_code;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs [4];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic write_bp(input logic [3:0] idx, input logic [15:0] addr,
                          input logic [15:0] mask, input logic en);
    bp_wr = 1'b1; bp_wr_idx = idx; bp_wr_addr = addr; bp_wr_mask = mask; bp_wr_en = en;
    tick();
    bp_wr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{div: 1'b0, fop: 16'hAAAA, frdy: 1'b1, rom: 16'h1111, rrdy: 1'b1, exp_code: 16'h1111, exp_rdy: 1'b1};
    vecs[1] = '{div: 1'b0, fop: 16'hAAAA, frdy: 1'b1, rom: 16'h2222, rrdy: 1'b0, exp_code: 16'h2222, exp_rdy: 1'b0};
    vecs[2] = '{div: 1'b1, fop: 16'hBBBB, frdy: 1'b0, rom: 16'h3333, rrdy: 1'b1, exp_code: 16'hBBBB, exp_rdy: 1'b0};
    vecs[3] = '{div: 1'b1, fop: 16'hCCCC, frdy: 1'b1, rom: 16'h4444, rrdy: 1'b0, exp_code: 16'hCCCC, exp_rdy: 1'b1};

    sysreset = 1'b1;
    rom_code_in = 16'h0000; rom_code_ready = 1'b1; tg_code_addr = 16'h0000;
    tg_debug_loading_exr = 1'b0; tg_debug_enable_exec = 1'b0;
    divert = 1'b0; force_opcode = 16'h0000; force_ready = 1'b0;
    bp_wr = 1'b0; bp_wr_idx = 4'd0; bp_wr_addr = 16'h0000; bp_wr_mask = 16'h0000; bp_wr_en = 1'b0;
    step_load = 1'b0; step_count = '0; resume = 1'b0;
    tick(); tick();
    sysreset = 1'b0;
    #1;

    // Reset state
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_hit_idx", 32'(hit_idx), 32'd0);
    chk("rst_exr", 32'(exr_shadow), 32'd0);
    chk("rst_step_left", 32'(step_left), 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_ready", 32'(tg_code_ready), 32'd1);

    // Disabled bp0 at address 0 never matches
    tg_code_addr = 16'h0000;
    tg_debug_enable_exec = 1'b1;
    tick(); tick(); tick();
    chk("dis_bp0_halted", 32'(halted), 32'd0);
    tg_debug_enable_exec = 1'b0;

    // EXR shadow: not captured under divert, captured otherwise
    rom_code_in = 16'h1234; tg_debug_loading_exr = 1'b1; divert = 1'b1;
    tick();
    chk("exr_divert", 32'(exr_shadow), 32'd0);
    divert = 1'b0;
    tick();
    chk("exr_load", 32'(exr_shadow), 32'h1234);
    tg_debug_loading_exr = 1'b0;

    // Code-bus mux table while running
    for (int i = 0; i < 4; i++) begin
      divert = vecs[i].div; force_opcode = vecs[i].fop; force_ready = vecs[i].frdy;
      rom_code_in = vecs[i].rom; rom_code_ready = vecs[i].rrdy;
      #1;
      chk($sformatf("mux_code[%0d]", i), 32'(tg_code_in), 32'(vecs[i].exp_code));
      chk($sformatf("mux_rdy[%0d]", i), 32'(tg_code_ready), 32'(vecs[i].exp_rdy));
    end
    divert = 1'b0; force_ready = 1'b0; rom_code_ready = 1'b1; rom_code_in = 16'h5555;
    tick();

    // Masked bp1: arm at 0x0127, halt on the next ordinary cycle
    write_bp(4'd1, 16'h0120, 16'h000F, 1'b1);
    tg_code_addr = 16'h0127;
    tick();
    chk("armed_not_halted", 32'(halted), 32'd0);
    tg_code_addr = 16'h0200; tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("bp1_halted", 32'(halted), 32'd1);
    chk("bp1_hit_idx", 32'(hit_idx), 32'd1);
    chk("bp1_ready_low", 32'(tg_code_ready), 32'd0);
    divert = 1'b1; force_ready = 1'b1; force_opcode = 16'h9ABC;
    #1;
    chk("halt_divert_rdy", 32'(tg_code_ready), 32'd1);
    chk("halt_divert_code", 32'(tg_code_in), 32'h9ABC);
    divert = 1'b0; force_ready = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_run", 32'(halted), 32'd0);

    // bp_wr in ARMED returns to RUN
    tg_code_addr = 16'h0127;
    tick();
    write_bp(4'd1, 16'h0120, 16'h000F, 1'b0);
    tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("armed_wr_run", 32'(halted), 32'd0);

    // Out-of-range write ignored; bp0 and bp2 both match 0x0040, lowest wins
    write_bp(4'd9, 16'h0127, 16'h0000, 1'b1);
    tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("oor_wr_ignored", 32'(halted), 32'd0);
    write_bp(4'd0, 16'h0040, 16'h0000, 1'b1);
    write_bp(4'd2, 16'h0000, 16'h00FF, 1'b1);
    tg_code_addr = 16'h0040; tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("dual_halted", 32'(halted), 32'd1);
    chk("dual_hit_idx", 32'(hit_idx), 32'd0);

    // Resume with skip: no re-hit while parked on 0x0040, re-hit after leaving
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tg_debug_enable_exec = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("skip_no_rehit[%0d]", c), 32'(halted), 32'd0);
    end
    tg_code_addr = 16'h0300;
    tick();
    chk("skip_left", 32'(halted), 32'd0);
    tg_code_addr = 16'h0040;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("skip_rehit", 32'(halted), 32'd1);

    // Resume + step_load 3: halt after the third executed instruction
    tg_code_addr = 16'h0500; resume = 1'b1; step_load = 1'b1; step_count = 8'd3;
    tick();
    resume = 1'b0; step_load = 1'b0;
    chk("step_loaded", 32'(step_left), 32'd3);
    tg_debug_enable_exec = 1'b1;
    tick();
    chk("step_2_left", 32'(step_left), 32'd2);
    chk("step_2_run", 32'(halted), 32'd0);
    tick();
    chk("step_1_run", 32'(halted), 32'd0);
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("step_halted", 32'(halted), 32'd1);
    chk("step_hit_idx", 32'(hit_idx), 32'(NUM_BP));
    chk("step_left_zero", 32'(step_left), 32'd0);
    chk("step_ready_low", 32'(tg_code_ready), 32'd0);

    // Single step that lands on a matching breakpoint: step wins
    resume = 1'b1; step_load = 1'b1; step_count = 8'd1;
    tick();
    resume = 1'b0; step_load = 1'b0;
    tg_code_addr = 16'h0040; tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("step_over_bp_halt", 32'(halted), 32'd1);
    chk("step_over_bp_idx", 32'(hit_idx), 32'(NUM_BP));

    // Reset mid-operation clears state and breakpoint table
    sysreset = 1'b1;
    #1;
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_hit_idx", 32'(hit_idx), 32'd0);
    tick();
    sysreset = 1'b0;
    tg_code_addr = 16'h0040; tg_debug_enable_exec = 1'b1;
    tick();
    tg_debug_enable_exec = 1'b0;
    chk("midrst_table_clear", 32'(halted), 32'd0);

`ifdef BP_HIT_COUNT_EN
    // Saturating hit counter on bp3, cleared by a write to bp3
    write_bp(4'd3, 16'h0700, 16'h0000, 1'b1);
    for (int n = 0; n < 300; n++) begin
      tg_code_addr = 16'h0700; tg_debug_enable_exec = 1'b1;
      tick();
      tg_debug_enable_exec = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0; tg_code_addr = 16'h0701;
      tick();
    end
    chk("hitcnt_sat", 32'(hit_count[31:24]), 32'd255);
    chk("hitcnt_other", 32'(hit_count[23:0]), 32'd0);
    write_bp(4'd3, 16'h0700, 16'h0000, 1'b1);
    chk("hitcnt_clear", 32'(hit_count[31:24]), 32'd0);
`else
    chk("hitcnt_tied", hit_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_unit.md
# bp_unit

Parametrised breakpoint, watch-step and code-bus arbitration unit for the visor debug supervisor. It sits between the target Synapse316 and its code ROM, and is driven by visor register writes. It provides NUM_BP maskable, individually enabled address breakpoints, an N-instruction step counter, and resume-with-skip so the target can leave a breakpoint address without re-hitting it. An EXR shadow capture is included, plus optional per-breakpoint hit counters.

## Interface
- NUM_BP, 4, number of address breakpoints (1..15)
- STEP_W, 8, width of step counter
- sysclk  in  1  clock
- sysreset  in  1  asynchronous, active-high reset
- rom_code_in  in  16  opcode from target code ROM
- rom_code_ready  in  1  ROM data valid
- tg_code_addr  in  16  target fetch address
- tg_code_in  out  16  opcode to target: force_opcode if divert else rom_code_in
- tg_code_ready  out  1  divert ? force_ready : (rom_code_ready && state!=HALTED)
- tg_debug_loading_exr  in  1  target is loading EXR this cycle
- tg_debug_enable_exec  in  1  target executes an ordinary assignment this cycle
- divert  in  1  visor owns code bus
- force_opcode  in  16  visor-forced opcode
- force_ready  in  1  visor-forced ready
- bp_wr  in  1  write breakpoint bp_wr_idx
- bp_wr_idx  in  4  breakpoint index; values >= NUM_BP ignored
- bp_wr_addr  in  16  breakpoint address
- bp_wr_mask  in  16  don't-care address bits (1 = ignore)
- bp_wr_en  in  1  breakpoint enable
- step_load  in  1  load step counter
- step_count  in  STEP_W  instructions to run before halting; 0 cancels stepping
- resume  in  1  leave HALTED
- halted  out  1  state==HALTED
- hit_idx  out  4  source of last halt: breakpoint index, or NUM_BP for step
- exr_shadow  out  16  last ROM word loaded into target EXR
- step_left  out  STEP_W  current step counter
- hit_count  out  8*NUM_BP  per-breakpoint hit counters, index i at [8i+7:8i]

## Operation
- Reset: state RUN; halted=0; hit_idx=0; exr_shadow=0; step_left=0; skip_valid=0; all bp addr/mask/en=0; hit_count=0. Disabled breakpoints never match, so address 0 does not hit after reset.
- match_i = en_i && ((tg_code_addr ^ addr_i) & ~mask_i)==0. match_any = OR of match_i, suppressed while skip_valid && tg_code_addr==skip_addr. Lowest matching index wins.
- States:
  - RUN: match_any && !enable_exec -> ARMED, latch idx. match_any && enable_exec -> HALTED, latch idx.
  - ARMED: enable_exec -> HALTED. Halt is deferred to an ordinary cycle so the visor can commandeer and refill EXR.
  - HALTED: tg_code_ready low unless divert. resume -> RUN; skip_addr <= tg_code_addr; skip_valid <= 1.
- skip_valid clears on the first cycle tg_code_addr != skip_addr.
- Step: step_load writes step_count into step_left in any state. In RUN, each enable_exec with step_left!=0 decrements it. A decrement to 0 -> HALTED with hit_idx=NUM_BP. A step halt overrides a simultaneous breakpoint match.
- bp_wr: updates entry on the next edge. A write in ARMED returns to RUN; a write in HALTED leaves state unchanged. Index out of range: no effect.
- exr_shadow <= rom_code_in when tg_debug_loading_exr && !divert.
- Simultaneous resume + step_load: both apply, giving single/N-step from a halt. Simultaneous resume + bp_wr: both apply.
- Reset mid-operation: immediate return to reset values, including breakpoint table.

## Timing
- Match is combinational on tg_code_addr; state and halted are registered, 1 cycle after the qualifying edge.
- tg_code_in and tg_code_ready are combinational; tg_code_ready drops in the same cycle halted rises.
- step_count=1 from HALTED+resume: exactly one enable_exec is executed, then HALTED.

## Configuration
- BP_HIT_COUNT_EN defined: hit_count[i] increments on each entry to HALTED caused by breakpoint i. It saturates at 255 and clears on bp_wr to i.
- BP_HIT_COUNT_EN undefined: hit_count tied to 0 and no counter flops are synthesised.

## Test plan
- Reset, bp0 addr 0 disabled, target fetches 0x0000 -> never halts; halted=0, exr_shadow=0.
- bp1 addr 0x0120, mask 0x000F, en; target reaches 0x0127, then enable_exec -> ARMED then HALTED, hit_idx=1, tg_code_ready=0.
- bp0 and bp2 both match 0x0040 with enable_exec high in the same cycle -> HALTED in 1 cycle, hit_idx=0.
- Halted at 0x0040, resume -> RUN. Addr stays 0x0040 for 3 cycles: no re-hit. Addr leaves, then returns to 0x0040 -> halts again.
- Halted, resume + step_load 3 -> after the third enable_exec, HALTED with hit_idx=NUM_BP and step_left=0.
- BP_HIT_COUNT_EN: hit bp3 300 times -> hit_count[3]=255; bp_wr idx 3 -> 0.
